// File: rtl/mod_counter_if.sv
// Control/status bundle for mod_counter; the prescale field exists only when
// MOD_COUNTER_PRESCALE_EN is defined.
interface mod_counter_if #(
  parameter int WIDTH = 6
`ifdef MOD_COUNTER_PRESCALE_EN
  , parameter int PRESCALE_W = 4
`endif
);
  logic             count_enable;
  logic             up_down;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] modulus;
  logic [WIDTH-1:0] count;
  logic             carry_out;
  logic             wrap_pulse;
`ifdef MOD_COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale;

  modport master (
    output count_enable, up_down, clear, load, load_value, modulus, prescale,
    input  count, carry_out, wrap_pulse
  );

  modport slave (
    input  count_enable, up_down, clear, load, load_value, modulus, prescale,
    output count, carry_out, wrap_pulse
  );
`else
  modport master (
    output count_enable, up_down, clear, load, load_value, modulus,
    input  count, carry_out, wrap_pulse
  );

  modport slave (
    input  count_enable, up_down, clear, load, load_value, modulus,
    output count, carry_out, wrap_pulse
  );
`endif
endinterface

// File: rtl/mod_counter.sv
// Programmable-modulus up/down counter with cascade carry and registered wrap pulse.
// Optional prescaler compiled in with MOD_COUNTER_PRESCALE_EN.
module mod_counter #(
  parameter int WIDTH      = 6,
  parameter int PRESCALE_W = 4
) (
  input  logic          clk,
  input  logic          reset,
  mod_counter_if.slave  bus
);

  if (WIDTH < 1 || PRESCALE_W < 1) begin : g_param_check
    $error("mod_counter: WIDTH and PRESCALE_W must be at least 1");
  end

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] last;
  logic             at_last;
  logic             at_zero;
  logic             over;
  logic             wrap_cond;
  logic             advance;
  logic             carry;
  logic             wrap_q;

`ifdef MOD_COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescaler;
  logic                  tick;

  assign tick    = (prescaler == bus.prescale);
  assign advance = bus.count_enable && tick;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
    end else if (bus.clear || bus.load) begin
      prescaler <= '0;
    end else if (bus.count_enable) begin
      prescaler <= tick ? '0 : prescaler + PRESCALE_W'(1);
    end
  end
`else
  assign advance = bus.count_enable;
`endif

  // A modulus of zero selects the full 2^WIDTH range.
  always_comb begin
    last = '1;
    if (bus.modulus != '0) begin
      last = bus.modulus - WIDTH'(1);
    end
  end

  always_comb begin
    at_last   = (count_q == last);
    at_zero   = (count_q == '0);
    over      = (count_q > last);
    wrap_cond = bus.up_down ? (at_last || over) : at_zero;
    carry     = advance && wrap_cond && !bus.clear && !bus.load;

    count_next = count_q;
    if (bus.clear) begin
      count_next = '0;
    end else if (bus.load) begin
      count_next = (bus.load_value > last) ? last : bus.load_value;
    end else if (advance) begin
      if (bus.up_down) begin
        count_next = (at_last || over) ? '0 : count_q + WIDTH'(1);
      end else if (at_zero || over) begin
        // Counting down from above a lowered modulus clamps to last without a wrap.
        count_next = last;
      end else begin
        count_next = count_q - WIDTH'(1);
      end
    end
  end

  // carry already folds in clear/load/enable, so the pulse simply follows it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_next;
      wrap_q  <= carry;
    end
  end

  assign bus.count      = count_q;
  assign bus.carry_out  = carry;
  assign bus.wrap_pulse = wrap_q;

endmodule

// File: tb/tb_mod_counter.sv
// Directed self-checking bench for mod_counter (WIDTH=6); the prescaler steps
// run only when MOD_COUNTER_PRESCALE_EN is defined.
module tb_mod_counter;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

`ifdef MOD_COUNTER_PRESCALE_EN
  mod_counter_if #(.WIDTH(6), .PRESCALE_W(4)) bus ();
`else
  mod_counter_if #(.WIDTH(6)) bus ();
`endif

  mod_counter #(.WIDTH(6), .PRESCALE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic en, input logic ud, input logic clr,
                                input logic ld, input logic [5:0] lv,
                                input logic [5:0] md);
    bus.count_enable = en;
    bus.up_down      = ud;
    bus.clear        = clr;
    bus.load         = ld;
    bus.load_value   = lv;
    bus.modulus      = md;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
`ifdef MOD_COUNTER_PRESCALE_EN
    bus.prescale = '0;
`endif
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
    repeat (2) tick();
    check_output("reset_count", bus.count, 0);
    check_output("reset_wrap", bus.wrap_pulse, 0);
    check_output("reset_carry", bus.carry_out, 0);

    // Full-range count to 17, then an asynchronous reset between edges
    reset = 1'b1;
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
    repeat (17) tick();
    check_output("count_to_17", bus.count, 17);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset_count", bus.count, 0);
    check_output("async_reset_wrap", bus.wrap_pulse, 0);
    tick();
    reset = 1'b1;
    tick();
    check_output("resume_after_reset", bus.count, 1);

    // modulus 10 counting up through one wrap
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 6'd0, 6'd10);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd10);
    for (int i = 0; i < 12; i++) begin
      check_output($sformatf("mod10_count_%0d", i), bus.count, i % 10);
      check_output($sformatf("mod10_carry_%0d", i), bus.carry_out, (i % 10) == 9);
      check_output($sformatf("mod10_wrap_%0d", i), bus.wrap_pulse, i == 10);
      tick();
    end

    // Full range counting down from 0
    apply_stimulus(1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 6'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd0);
    check_output("down_carry_at_0", bus.carry_out, 1);
    tick();
    check_output("down_count_63", bus.count, 63);
    check_output("down_wrap_63", bus.wrap_pulse, 1);
    tick();
    check_output("down_count_62", bus.count, 62);
    check_output("down_wrap_62", bus.wrap_pulse, 0);
    tick();
    check_output("down_count_61", bus.count, 61);

    // Load clamping, clear priority and counts above a lowered modulus
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'd50, 6'd40);
    check_output("load_carry", bus.carry_out, 0);
    tick();
    check_output("load_clamped", bus.count, 39);
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 6'd50, 6'd40);
    tick();
    check_output("clear_over_load", bus.count, 0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'd45, 6'd0);
    tick();
    check_output("load_45", bus.count, 45);
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd40);
    check_output("over_up_carry", bus.carry_out, 1);
    tick();
    check_output("over_up_count", bus.count, 0);
    check_output("over_up_wrap", bus.wrap_pulse, 1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'd45, 6'd0);
    tick();
    check_output("reload_45", bus.count, 45);
    check_output("reload_wrap", bus.wrap_pulse, 0);
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 6'd40);
    check_output("over_down_carry", bus.carry_out, 0);
    tick();
    check_output("over_down_count", bus.count, 39);
    check_output("over_down_wrap", bus.wrap_pulse, 0);

    // Hold with count_enable low
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'd7, 6'd0);
    tick();
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
    for (int i = 0; i < 5; i++) begin
      check_output($sformatf("hold_count_%0d", i), bus.count, 7);
      check_output($sformatf("hold_carry_%0d", i), bus.carry_out, 0);
      check_output($sformatf("hold_wrap_%0d", i), bus.wrap_pulse, 0);
      tick();
    end
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0);
    tick();
    check_output("hold_release", bus.count, 8);

`ifdef MOD_COUNTER_PRESCALE_EN
    // Prescale 2: one advance every third enabled cycle
    bus.prescale = 4'd2;
    apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 6'd4);
    tick();
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd4);
    for (int k = 1; k <= 12; k++) begin
      check_output($sformatf("pre_carry_%0d", k), bus.carry_out, k == 12);
      tick();
      check_output($sformatf("pre_count_%0d", k), bus.count, (k / 3) % 4);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
Name: mod_counter

Overview:
- Parametrised, programmable-modulus up/down counter. Next generation of the team's 6-bit enable counter.
- Adds runtime modulus, direction control, synchronous load/clear, a combinational cascade carry and a registered wrap pulse.
- Used as a general event/timebase counter. Instances chain through carry_out -> count_enable.

Parameters:
- WIDTH, 6, counter width in bits.
- PRESCALE_W, 4, prescaler width; used only when MOD_COUNTER_PRESCALE_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- count_enable  input  1  advance request, sampled each rising edge.
- up_down  input  1  direction: 1 = up, 0 = down.
- clear  input  1  synchronous clear to 0.
- load  input  1  synchronous load of load_value.
- load_value  input  WIDTH  value to load.
- modulus  input  WIDTH  count length. last = modulus-1; modulus==0 means full range, last = 2^WIDTH-1.
- count  output  WIDTH  registered count value.
- carry_out  output  1  combinational. High when an advance this cycle wraps.
- wrap_pulse  output  1  registered. High for one cycle after each wrap.

Behaviour:
- Reset (reset=0, asynchronous, any time, including mid-operation): count=0, wrap_pulse=0, prescaler=0. Outputs go low immediately, not at the next edge.
- Priority per edge: clear > load > advance > hold.
- clear=1: count<=0, wrap_pulse<=0, prescaler<=0. This applies regardless of load and count_enable.
- load=1 (clear=0): count<=min(load_value, last), wrap_pulse<=0, prescaler<=0.
- advance = count_enable and (prescaler tick, if compiled in). When advance=1:
  - Up: count==last -> 0 (wrap). count>last (modulus lowered at runtime) -> 0 (wrap). Otherwise count+1.
  - Down: count==0 -> last (wrap). count>last -> last (no wrap). Otherwise count-1.
- carry_out = advance and wrap condition, with clear=0 and load=0. No register, so zero latency for cascading.
- wrap_pulse <= carry_out. It is high in the cycle in which count shows the wrapped value.
- count_enable=0: count, wrap_pulse and prescaler hold. Exception: wrap_pulse returns to 0 the cycle after a pulse.
- up_down and modulus may change on any cycle. They take effect at the next edge and need no drain.
- All arithmetic is modulo 2^WIDTH. There is no X-propagation from an unused load_value when load=0.

Optional Feature:
- Macro MOD_COUNTER_PRESCALE_EN.
- Defined:
  - Adds input prescale [PRESCALE_W-1:0] and an internal prescaler counter.
  - With count_enable=1 the prescaler counts 0..prescale. The tick is high when prescaler==prescale; the prescaler then returns to 0.
  - count advances only on tick, giving one advance per (prescale+1) enabled cycles. prescale=0 means every enabled cycle.
  - count_enable=0 freezes the prescaler.
  - clear, load and reset zero the prescaler.
- Undefined: no prescale port and no prescaler logic. advance = count_enable.

Test Plan (WIDTH=6):
- Count up to 17, then pulse reset low mid-cycle -> count=0 and wrap_pulse=0 before the next edge. Counting resumes from 0 after release.
- modulus=10, up_down=1, count_enable=1 from 0 for 12 cycles -> count 0..9,0,1. carry_out=1 only while count=9; wrap_pulse=1 only while count=0 (second pass).
- modulus=0, up_down=0, count=0, enable -> carry_out=1, next count=63, then 62, 61.
- modulus=40, load=1, load_value=50 -> count=39. Same cycle clear=1 and load=1 -> count=0. count=45 with modulus=40: up -> 0 with wrap_pulse=1; down -> 39 with no wrap_pulse.
- At count=7, drop count_enable for 5 cycles -> count holds 7, carry_out=0, wrap_pulse=0.
- MOD_COUNTER_PRESCALE_EN defined, prescale=2, modulus=4, up, enable 12 cycles -> count advances on cycles 3,6,9,12: values 1,2,3,0. carry_out=1 only on cycle 12.
